// File: rtl/vidac_line_engine.sv
// vidac_line_engine: polls a command block in its 256 KiB window, then
// plots a single pixel (PSET) or a Bresenham line (LINE) into a 320x200
// 8bpp framebuffer at window offset 0. Completion is signalled by writing
// 00h over the opcode byte. All bus outputs are registered and carry the
// values that belong to the state being entered, so a write is on the
// bus during the DRAW/ACK cycle that produces it.
module vidac_line_engine #(
  parameter logic [17:0] CMD_BASE = 18'h20000,
  parameter int          SCR_W    = 320,
  parameter int          SCR_H    = 200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd,
  output logic [17:0] a,
  input  logic [7:0]  i,
  output logic [7:0]  o,
  output logic        w
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_SETUP  = 3'd3;
  localparam logic [2:0] S_DRAW   = 3'd4;
  localparam logic [2:0] S_ACK    = 3'd5;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_PSET = 8'h01;
  localparam logic [7:0] OP_LINE = 8'h05;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [17:0] a_q, a_d;
  logic [7:0]  o_q, o_d;
  logic        w_q, w_d;

  // Current pixel, line end point, Bresenham terms and step directions
  logic signed [17:0] x_q, x_d, y_q, y_d;
  logic signed [17:0] xe_q, xe_d, ye_q, ye_d;
  logic signed [17:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic               sxn_q, sxn_d, syn_q, syn_d;

  // Captured command block bytes 0..9, flattened little-endian
  logic [79:0] blk_w;
  logic [9:0]  cap_en;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_blk
      logic [7:0] b_q;
      // Byte gi arrives one cycle after its address, i.e. in FETCH step gi+1
      assign cap_en[gi] = (state_q == S_FETCH) && (cnt_q == 4'(gi + 1));
      // Capture one command byte when its read data is valid
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          b_q <= 8'h00;
        end else if (cap_en[gi]) begin
          b_q <= i;
        end
      end
      assign blk_w[gi*8 +: 8] = b_q;
    end
  endgenerate

  logic [7:0]         opcode;
  logic [7:0]         color;
  logic signed [17:0] x1, y1, x2, y2;

  assign opcode = blk_w[7:0];
  assign x1     = {{2{blk_w[23]}}, blk_w[23:8]};
  assign y1     = {{2{blk_w[39]}}, blk_w[39:24]};
  assign x2     = {{2{blk_w[55]}}, blk_w[55:40]};
  assign y2     = {{2{blk_w[71]}}, blk_w[71:56]};
  assign color  = blk_w[79:72];

  // Line setup terms, derived directly from the captured end points
  logic signed [17:0] diff_x, diff_y, abs_x, abs_y;
  assign diff_x = x2 - x1;
  assign diff_y = y2 - y1;
  assign abs_x  = diff_x[17] ? -diff_x : diff_x;
  assign abs_y  = diff_y[17] ? -diff_y : diff_y;

  // One Bresenham step from the current pixel; both tests use the old err
  logic signed [18:0] e2;
  logic               step_x, step_y;
  logic signed [17:0] err_n, x_n, y_n;
  assign e2     = {err_q, 1'b0};
  assign step_x = (e2 >= $signed({dy_q[17], dy_q}));
  assign step_y = (e2 <= $signed({dx_q[17], dx_q}));
  assign err_n  = err_q + (step_x ? dy_q : 18'sd0) + (step_y ? dx_q : 18'sd0);
  assign x_n    = step_x ? (sxn_q ? x_q - 18'sd1 : x_q + 18'sd1) : x_q;
  assign y_n    = step_y ? (syn_q ? y_q - 18'sd1 : y_q + 18'sd1) : y_q;

  // Linear framebuffer address y*320+x built from shifts, 17 bits wide
  function automatic logic [17:0] pix_addr(input logic signed [17:0] px,
                                           input logic signed [17:0] py);
    logic [16:0] yv;
    logic [16:0] xv;
    logic [16:0] sum;
    yv  = py[16:0];
    xv  = px[16:0];
    sum = (yv << 8) + (yv << 6) + xv;
    return {1'b0, sum};
  endfunction

  // Off-screen pixels still take their cycle but never strobe w
  function automatic logic pix_on(input logic signed [17:0] px,
                                  input logic signed [17:0] py);
    return (px >= 18'sd0) && (px < $signed(18'(SCR_W))) &&
           (py >= 18'sd0) && (py < $signed(18'(SCR_H)));
  endfunction

  // Next-state and next-output selection for the command sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    o_d     = o_q;
    w_d     = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;

    case (state_q)
      S_IDLE: begin
        if (cmd) begin
          state_d = S_FETCH;
          cnt_d   = 4'd0;
          a_d     = CMD_BASE;
        end
      end

      S_FETCH: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q < 4'd9) begin
          a_d = CMD_BASE + 18'(cnt_q) + 18'd1;
        end
        if (cnt_q == 4'd10) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_NOP: begin
            state_d = S_IDLE;
          end
          OP_PSET: begin
            // A PSET is drawn as a one-pixel line ending where it starts
            state_d = S_DRAW;
            x_d     = x1;
            y_d     = y1;
            xe_d    = x1;
            ye_d    = y1;
            a_d     = pix_addr(x1, y1);
            o_d     = color;
            w_d     = pix_on(x1, y1);
          end
          OP_LINE: begin
            state_d = S_SETUP;
          end
          default: begin
            state_d = S_ACK;
            a_d     = CMD_BASE;
            o_d     = 8'h00;
            w_d     = 1'b1;
          end
        endcase
      end

      S_SETUP: begin
        state_d = S_DRAW;
        dx_d    = abs_x;
        dy_d    = -abs_y;
        err_d   = abs_x - abs_y;
        sxn_d   = !(x1 < x2);
        syn_d   = !(y1 < y2);
        x_d     = x1;
        y_d     = y1;
        xe_d    = x2;
        ye_d    = y2;
        a_d     = pix_addr(x1, y1);
        o_d     = color;
        w_d     = pix_on(x1, y1);
      end

      S_DRAW: begin
        if ((x_q == xe_q) && (y_q == ye_q)) begin
          state_d = S_ACK;
          a_d     = CMD_BASE;
          o_d     = 8'h00;
          w_d     = 1'b1;
        end else begin
          x_d   = x_n;
          y_d   = y_n;
          err_d = err_n;
          a_d   = pix_addr(x_n, y_n);
          o_d   = color;
          w_d   = pix_on(x_n, y_n);
        end
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, bus output and draw registers; reset aborts any command at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 18'd0;
      o_q     <= 8'h00;
      w_q     <= 1'b0;
      x_q     <= 18'sd0;
      y_q     <= 18'sd0;
      xe_q    <= 18'sd0;
      ye_q    <= 18'sd0;
      dx_q    <= 18'sd0;
      dy_q    <= 18'sd0;
      err_q   <= 18'sd0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      o_q     <= o_d;
      w_q     <= w_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
    end
  end

  assign a = a_q;
  assign o = o_q;
  assign w = w_q;

endmodule

// File: tb/tb_vidac_line_engine.sv
// Bench for vidac_line_engine: a behavioural shared memory with one-cycle
// read latency, a scoreboard of expected writes filled when each command
// is issued, and a negedge monitor that pops and compares every write.
module tb_vidac_line_engine;

  localparam logic [17:0] BASE = 18'h20000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd   = 1'b0;
  logic [17:0] a;
  logic [7:0]  i = 8'h00;
  logic [7:0]  o;
  logic        w;

  always #5 clock = ~clock;

  vidac_line_engine dut (
    .clock (clock),
    .reset (reset),
    .cmd   (cmd),
    .a     (a),
    .i     (i),
    .o     (o),
    .w     (w)
  );

  // Shared memory: engine writes win, host writes load command blocks
  logic [7:0]  mem [0:262143];
  logic        host_we   = 1'b0;
  logic [17:0] host_addr = 18'd0;
  logic [7:0]  host_data = 8'h00;

  always @(posedge clock) begin
    if (w) mem[a] <= o;
    else if (host_we) mem[host_addr] <= host_data;
    i <= mem[a];
  end

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [17:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t log_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // Every strobed write is logged and checked against the scoreboard head
  always @(negedge clock) begin
    wr_t e;
    if (!reset && w) begin
      log_q.push_back({a, o});
      $display("write a=%05h o=%02h", a, o);
      if (exp_q.size() == 0) begin
        chk("spurious_w", 32'(w), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(a), 32'(e.addr));
        chk("wr_data", 32'(o), 32'(e.data));
      end
    end
  end

  task automatic host_wr(input logic [17:0] ad, input logic [7:0] d);
    @(negedge clock);
    host_we   = 1'b1;
    host_addr = ad;
    host_data = d;
    @(negedge clock);
    host_we   = 1'b0;
  endtask

  // Arguments first, opcode last, so a live poll never sees a half block
  task automatic load_cmd(input logic [7:0] op, input int x1, input int y1,
                          input int x2, input int y2, input logic [7:0] col);
    host_wr(BASE + 18'd1, x1[7:0]);
    host_wr(BASE + 18'd2, x1[15:8]);
    host_wr(BASE + 18'd3, y1[7:0]);
    host_wr(BASE + 18'd4, y1[15:8]);
    host_wr(BASE + 18'd5, x2[7:0]);
    host_wr(BASE + 18'd6, x2[15:8]);
    host_wr(BASE + 18'd7, y2[7:0]);
    host_wr(BASE + 18'd8, y2[15:8]);
    host_wr(BASE + 18'd9, col);
    host_wr(BASE, op);
  endtask

  task automatic push_ack();
    exp_q.push_back({BASE, 8'h00});
  endtask

  // Reference rasteriser: plain Bresenham on ints, on-screen pixels only
  task automatic push_line(input int x1, input int y1, input int x2, input int y2,
                           input logic [7:0] col);
    int x, y, dx, dy, sx, sy, err, e2;
    x   = x1;
    y   = y1;
    dx  = (x2 > x1) ? x2 - x1 : x1 - x2;
    dy  = -((y2 > y1) ? y2 - y1 : y1 - y2);
    sx  = (x1 < x2) ? 1 : -1;
    sy  = (y1 < y2) ? 1 : -1;
    err = dx + dy;
    for (int n = 0; n < 2000; n++) begin
      if (x >= 0 && x < 320 && y >= 0 && y < 200)
        exp_q.push_back({18'(y * 320 + x), col});
      if (x == x2 && y == y2) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    push_ack();
  endtask

  // Issue the loaded command, wait for all expected writes, then let the
  // engine poll the cleared opcode for a while before dropping cmd
  task automatic run_cmd(input string tag);
    int n;
    n   = 0;
    cmd = 1'b1;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    repeat (30) @(negedge clock);
    cmd = 1'b0;
    repeat (15) @(negedge clock);
  endtask

  initial begin
    int n, cnt_aa, bad, nlog;
    int ya, yb, xa, xb;

    // Reset state
    @(posedge clock);
    #1;
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_o", 32'(o), 32'd0);
    chk("rst_w", 32'(w), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // LINE (160,100) -> (80,18)
    load_cmd(8'h05, 160, 100, 80, 18, 8'hAA);
    log_q.delete();
    push_line(160, 100, 80, 18, 8'hAA);
    run_cmd("line");
    chk("line_nwrites", 32'(log_q.size()), 32'd84);
    if (log_q.size() == 84) begin
      chk("line_first_a", 32'(log_q[0].addr), 32'h7DA0);
      chk("line_last_a", 32'(log_q[82].addr), 32'h16D0);
      chk("line_ack_a", 32'(log_q[83].addr), 32'h20000);
      chk("line_ack_o", 32'(log_q[83].data), 32'h00);
      cnt_aa = 0;
      bad    = 0;
      for (int k = 0; k < 83; k++) if (log_q[k].data == 8'hAA) cnt_aa++;
      for (int k = 0; k < 82; k++) begin
        ya = int'(log_q[k].addr) / 320;
        xa = int'(log_q[k].addr) % 320;
        yb = int'(log_q[k+1].addr) / 320;
        xb = int'(log_q[k+1].addr) % 320;
        if (yb != ya - 1 || xb > xa) bad++;
      end
      chk("line_aa_count", 32'(cnt_aa), 32'd83);
      chk("line_step_viol", 32'(bad), 32'd0);
    end

    // PSET at the top-left corner
    load_cmd(8'h01, 0, 0, 0, 0, 8'h55);
    log_q.delete();
    push_line(0, 0, 0, 0, 8'h55);
    run_cmd("pset0");
    chk("pset0_nwrites", 32'(log_q.size()), 32'd2);

    // PSET at the bottom-right corner
    load_cmd(8'h01, 319, 199, 0, 0, 8'h55);
    log_q.delete();
    push_line(319, 199, 319, 199, 8'h55);
    run_cmd("pset1");
    chk("pset1_nwrites", 32'(log_q.size()), 32'd2);
    if (log_q.size() >= 1) chk("pset1_a", 32'(log_q[0].addr), 32'hF9FF);

    // Horizontal line clipped on the left edge
    load_cmd(8'h05, -5, 10, 5, 10, 8'h11);
    log_q.delete();
    push_line(-5, 10, 5, 10, 8'h11);
    run_cmd("clip");
    chk("clip_nwrites", 32'(log_q.size()), 32'd7);
    if (log_q.size() >= 6) begin
      chk("clip_first_a", 32'(log_q[0].addr), 32'h0C80);
      chk("clip_last_a", 32'(log_q[5].addr), 32'h0C85);
    end

    // Unknown opcode: acknowledge only
    load_cmd(8'h07, 1, 1, 2, 2, 8'h22);
    log_q.delete();
    push_ack();
    run_cmd("unk");
    chk("unk_nwrites", 32'(log_q.size()), 32'd1);

    // Opcode 00h with cmd held: continuous fetch loop, no writes
    log_q.delete();
    cmd = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      n = 0;
      while (a !== 18'h20001 && n < 100) begin
        @(negedge clock);
        n++;
      end
      chk("poll_start", 32'(a), 32'h20001);
      for (int k = 2; k <= 9; k++) begin
        @(negedge clock);
        chk("poll_addr", 32'(a), 32'h20000 + 32'(k));
      end
    end
    cmd = 1'b0;
    repeat (20) @(negedge clock);
    chk("idle_a_hold0", 32'(a), 32'h20009);
    repeat (20) @(negedge clock);
    chk("idle_a_hold1", 32'(a), 32'h20009);
    chk("poll_nwrites", 32'(log_q.size()), 32'd0);

    // Asynchronous reset in the middle of a line
    load_cmd(8'h05, 160, 100, 80, 18, 8'hAA);
    log_q.delete();
    push_line(160, 100, 80, 18, 8'hAA);
    cmd = 1'b1;
    n   = 0;
    while (log_q.size() < 10 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("mid_draw_reached", 32'(log_q.size() >= 10), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_a", 32'(a), 32'd0);
    chk("async_rst_o", 32'(o), 32'd0);
    chk("async_rst_w", 32'(w), 32'd0);
    exp_q.delete();
    cmd = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    nlog  = log_q.size();
    repeat (25) @(negedge clock);
    chk("post_rst_a", 32'(a), 32'd0);
    chk("post_rst_nwrites", 32'(log_q.size()), 32'(nlog));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vidac_line_engine.md
Name: vidac_line_engine

Overview:
- Small video drawing accelerator.
- Polls a command block in its own 256 KiB memory window.
- Decodes the command and rasterises pixels into a 320x200, 8-bit-per-pixel linear framebuffer at window offset 0.
- Sits beside the CPU on a shared memory. The window base is mapped at system address A0000h, so the command block (offset 20000h) appears at C0000h.

Parameters:
- CMD_BASE, 18'h20000, window offset of the command block.
- SCR_W, 320, framebuffer width in pixels (also the row stride in bytes).
- SCR_H, 200, framebuffer height in pixels.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd  in  1  enable: while 1, the engine polls the command block whenever idle.
- a  out  18  window address for both reads and writes.
- i  in  8  read data for the address presented on the previous cycle.
- o  out  8  write data.
- w  out  1  write strobe; memory[a] <= o on a clock edge where w=1.

Behaviour:
- Interface and reset:
  - All outputs are registered.
  - While reset=1: a=0, o=0, w=0, state=IDLE, all internal registers cleared.
  - Reset during any state aborts the operation immediately; no further writes occur.
- Read timing: a is presented in cycle k; i is sampled at the edge ending cycle k+1. Reads are pipelined, one byte per cycle.
- Command block layout (offsets from CMD_BASE):
  - +0 opcode.
  - +1/+2 x1, +3/+4 y1, +5/+6 x2, +7/+8 y2; each is a signed 16-bit little-endian value.
  - +9 color, +10 reserved.
- States and transitions:
  - IDLE: w=0. If cmd=1, set a=CMD_BASE and go to FETCH.
  - FETCH: present CMD_BASE+0 through +9 on consecutive cycles and capture bytes 0..9; takes 11 cycles. Then go to DECODE.
  - DECODE:
    - Opcode 00h: go to IDLE with no write.
    - Opcode 01h (PSET): plot (x1,y1), then go to ACK.
    - Opcode 05h (LINE): go to SETUP.
    - Any other opcode: go to ACK with no drawing.
  - SETUP (one cycle):
    - dx=|x2-x1|, dy=-|y2-y1|.
    - sx=+1 if x1<x2 else -1; sy=+1 if y1<y2 else -1.
    - err=dx+dy, (x,y)=(x1,y1).
    - Arithmetic is 18-bit signed (err, dx, dy; e2=2*err is 19-bit).
  - DRAW (one pixel per cycle):
    - Plot (x,y).
    - If x==x2 and y==y2, go to ACK.
    - Else e2=2*err. If e2>=dy: err+=dy, x+=sx. If e2<=dx: err+=dx, y+=sy. Both updates use the old err and apply in the same cycle.
  - ACK: a=CMD_BASE, o=00h, w=1 for one cycle (clears the opcode, signalling completion to software). Then go to IDLE.
- Plot rule:
  - If 0<=x<SCR_W and 0<=y<SCR_H: a=y*320+x (computed as (y<<8)+(y<<6)+x, 17 bits), o=color, w=1.
  - Otherwise w=0 for that cycle. The cycle is still consumed and the line continues (clipping by skip).
- Total pixel cycles for a line = max(|dx|,|dy|)+1.
- w is never asserted in IDLE, FETCH, DECODE or SETUP.
- cmd is sampled only in IDLE. Dropping cmd mid-command does not abort; the command completes including ACK.
- Polling: with cmd held at 1 and opcode 00h, the engine re-fetches continuously (IDLE→FETCH→DECODE→IDLE loop) with no writes.

Test Plan:
- Reset: hold reset=1 mid-DRAW → a=0, o=0, w=0 immediately (asynchronous). After release with cmd=0, the engine stays IDLE and w stays 0.
- LINE: command block = 05, x1=160, y1=100, x2=80, y2=18, color=AAh, cmd=1.
  - Exactly 83 writes of AAh.
  - First write at a=7DA0h (100*320+160); last pixel write at a=16D0h (18*320+80).
  - Each successive y decreases by 1; x is non-increasing.
  - Then one write a=20000h, o=00h, followed by idle polling with no writes.
- PSET: opcode 01, (0,0), color=55h → single write a=0, o=55h, then ACK write at 20000h.
- PSET: opcode 01, (319,199), color=55h → single write a=F9FFh, o=55h, then ACK write at 20000h.
- Clipping: LINE (-5,10)→(5,10), color=11h → 11 DRAW cycles; writes only for x=0..5 (a=0C80h..0C85h), no writes for negative x; then ACK.
- Unknown opcode 07h → no pixel writes; one ACK write (20000h←00h).
- Opcode 00h with cmd=1 → repeated fetches of 20000h..20009h, w never asserted. With cmd=0 → a stays constant, no reads.
